fsm_cmd_tx: RTL

// - Transmit side of the start/jos/mijloc/sus/sfarsit control interface consumed by the casex-coded level FSMs.
// - Buffers level commands from a producer (valid/ready).
// - Frames them as: start pulse, one one-hot level pulse per command with a programmable gap between pulses, then a sfarsit pulse.
// - Sits between the command sequencer and any downstream level FSM.

---
 rtl/fsm_cmd_pkg.sv | 42 ++++
 rtl/fsm_cmd_fifo.sv | 63 ++++++
 rtl/fsm_cmd_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fsm_cmd_pkg.sv
// Shared types and constants for the level-command transmitter.
// - state_e    : framing FSM states
// - cmd_code_e : level command encodings (11 is reserved)
// - entry_t    : FIFO entry {last, code}
// - level_onehot() : code -> {jos, mijloc, sus}
package fsm_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_START = 3'b001,
    S_LEVEL = 3'b010,
    S_GAP   = 3'b011,
    S_END   = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    CMD_JOS    = 2'b00,
    CMD_MIJLOC = 2'b01,
    CMD_SUS    = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_code_e;

  localparam int unsigned ENTRY_W = 3;

  typedef struct packed {
    logic       last;
    logic [1:0] code;
  } entry_t;

  // Returns {jos, mijloc, sus}; the reserved code maps to no level.
  function automatic logic [2:0] level_onehot(input logic [1:0] code);
    logic [2:0] oh;
    case (code)
      CMD_JOS:    oh = 3'b100;
      CMD_MIJLOC: oh = 3'b010;
      CMD_SUS:    oh = 3'b001;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/fsm_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH bits.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   push_i, wdata_i     write request / data (ignored when full)
//   pop_i               read request (ignored when empty)
//   rdata_o             head entry, valid whenever empty_o is low
//   full_o, empty_o     status
//   count_o             number of stored entries
module fsm_cmd_fifo
  import fsm_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fsm_cmd_tx.sv
// Transmit side of the start/jos/mijloc/sus/sfarsit level-FSM interface.
// Buffers level commands (valid/ready) and frames them as: start, one one-hot
// level pulse per command each followed by GAP_CYCLES idle cycles, then sfarsit.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_code/cmd_last   producer handshake
//   start, jos, mijloc, sus, sfarsit        registered protocol pulses
//   busy                            FSM outside S_IDLE
//   err_code                        reserved code accepted and dropped
//   underrun                        FIFO empty when a level pulse was due
//   frame_cnt                       completed frames (only with FSM_CMD_TX_FRAME_CNT_EN)
module fsm_cmd_tx
  import fsm_cmd_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_code,
  input  logic       cmd_last,
  output logic       start,
  output logic       jos,
  output logic       mijloc,
  output logic       sus,
  output logic       sfarsit,
  output logic       busy,
  output logic       err_code,
  output logic       underrun
`ifdef FSM_CMD_TX_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned    CntW    = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  // Gap counter counts down to zero, so it is loaded with one less than the gap.
  localparam logic [3:0]     GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic            rdy_en_q;
  logic            xfer, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  entry_t          head, wentry;

  state_e     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       last_q, last_d;
  logic       uflag_q, uflag_d;
  logic       emit_try;
  logic [2:0] lvl;

  logic start_q, start_d, jos_q, jos_d, mijloc_q, mijloc_d, sus_q, sus_d;
  logic sfarsit_q, sfarsit_d, busy_q, busy_d, err_q, err_d, under_q, under_d;

  // Ready is held low through reset and follows the occupancy only.
  assign cmd_ready = rdy_en_q & (fifo_count != DepthC);
  assign xfer      = cmd_valid & cmd_ready;
  assign push      = xfer & (cmd_code != CMD_RSVD) & ~fifo_full;
  assign wentry    = '{last: cmd_last, code: cmd_code};

  fsm_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Outputs are computed for the state being entered, so each pulse is
  // visible in the cycle its state occupies.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    last_d    = last_q;
    uflag_d   = uflag_q;
    pop       = 1'b0;
    emit_try  = 1'b0;
    lvl       = 3'b000;
    start_d   = 1'b0;
    sfarsit_d = 1'b0;
    under_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          start_d = 1'b1;
        end
      end
      S_START: emit_try = 1'b1;
      S_LEVEL: begin
        // A level output high now means this cycle carries a popped pulse;
        // otherwise the FSM is waiting out an underrun.
        if (jos_q | mijloc_q | sus_q) begin
          if (GAP_CYCLES != 0) begin
            state_d = S_GAP;
            gap_d   = GapLoad;
          end else if (last_q) begin
            state_d   = S_END;
            sfarsit_d = 1'b1;
          end else begin
            emit_try = 1'b1;
          end
        end else begin
          emit_try = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (last_q) begin
          state_d   = S_END;
          sfarsit_d = 1'b1;
        end else begin
          emit_try = 1'b1;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit_try) begin
      state_d = S_LEVEL;
      if (!fifo_empty) begin
        pop     = 1'b1;
        uflag_d = 1'b0;
        last_d  = head.last;
        lvl     = level_onehot(head.code);
      end else begin
        // One underrun pulse per empty episode.
        under_d = ~uflag_q;
        uflag_d = 1'b1;
      end
    end

    jos_d    = lvl[2];
    mijloc_d = lvl[1];
    sus_d    = lvl[0];
    busy_d   = (state_d != S_IDLE);
    err_d    = xfer & (cmd_code == CMD_RSVD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en_q  <= 1'b0;
      state_q   <= S_IDLE;
      gap_q     <= 4'd0;
      last_q    <= 1'b0;
      uflag_q   <= 1'b0;
      start_q   <= 1'b0;
      jos_q     <= 1'b0;
      mijloc_q  <= 1'b0;
      sus_q     <= 1'b0;
      sfarsit_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      state_q   <= state_d;
      gap_q     <= gap_d;
      last_q    <= last_d;
      uflag_q   <= uflag_d;
      start_q   <= start_d;
      jos_q     <= jos_d;
      mijloc_q  <= mijloc_d;
      sus_q     <= sus_d;
      sfarsit_q <= sfarsit_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      under_q   <= under_d;
    end
  end

  assign start    = start_q;
  assign jos      = jos_q;
  assign mijloc   = mijloc_q;
  assign sus      = sus_q;
  assign sfarsit  = sfarsit_q;
  assign busy     = busy_q;
  assign err_code = err_q;
  assign underrun = under_q;

`ifdef FSM_CMD_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts with the sfarsit pulse; reset aborts never reach it.
  always_comb begin
    frame_cnt_d = sfarsit_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
